// File: rtl/pipe_stage_ctrl_if.sv
// Handshake bundle between the stage controller and its neighbours: the hazard
// unit and fetch drive stall/flush and F-stage data; stage contents flow back.
interface pipe_stage_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             flush;
    logic [31:0]      instr_f;
    logic [31:0]      pc_f;
    logic [4:0]       a3_d;

    logic             pc_en;
    logic [31:0]      instr_d;
    logic [31:0]      instr_e;
    logic [31:0]      instr_m;
    logic [31:0]      instr_w;
    logic [31:0]      pc_d;
    logic [31:0]      pc_e;
    logic [31:0]      pc_m;
    logic [31:0]      pc_w;
    logic [4:0]       a3_e;
    logic [4:0]       a3_m;
    logic [4:0]       a3_w;
    logic             bubble_e;
    logic [CNT_W-1:0] stall_cycles;

    // Fetch/hazard side: drives control and F-stage data, observes stage contents
    modport master (
        output stall, flush, instr_f, pc_f, a3_d,
        input  pc_en, instr_d, instr_e, instr_m, instr_w,
        input  pc_d, pc_e, pc_m, pc_w, a3_e, a3_m, a3_w, bubble_e, stall_cycles
    );

    modport slave (
        input  stall, flush, instr_f, pc_f, a3_d,
        output pc_en, instr_d, instr_e, instr_m, instr_w,
        output pc_d, pc_e, pc_m, pc_w, a3_e, a3_m, a3_w, bubble_e, stall_cycles
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// D/E/M/W pipeline registers for the five-stage MIPS core, applying hazard-unit
// stalls (freeze F/D, bubble E) and exception flushes, with a stall-cycle counter.
module pipe_stage_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] NOP      = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input logic              clk,
    input logic              reset_n,
    pipe_stage_ctrl_if.slave bus
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } dStage_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  a3;
    } stage_t;

    localparam dStage_t EMPTY_D = '{instr: NOP, pc: PC_RESET};
    localparam stage_t  EMPTY   = '{instr: NOP, pc: PC_RESET, a3: 5'd0};

    dStage_t          dStage_q, dStage_d;
    stage_t           eStage_q, eStage_d;
    stage_t           mStage_q, mStage_d;
    stage_t           wStage_q, wStage_d;
    logic             bubbleE_q, bubbleE_d;
    logic [CNT_W-1:0] stallCycles_q, stallCycles_d;

    // Flush wins over stall; W always takes M so the instruction leaving M commits
    always_comb begin
        dStage_d      = dStage_q;
        eStage_d      = eStage_q;
        mStage_d      = eStage_q;
        wStage_d      = mStage_q;
        bubbleE_d     = 1'b0;
        stallCycles_d = stallCycles_q;

        if (bus.flush) begin
            dStage_d = EMPTY_D;
            eStage_d = EMPTY;
            mStage_d = EMPTY;
        end else if (bus.stall) begin
            // The bubble keeps pc_d so an exception raised on it still has an EPC
            eStage_d  = '{instr: NOP, pc: dStage_q.pc, a3: 5'd0};
            bubbleE_d = 1'b1;
            if (stallCycles_q != {CNT_W{1'b1}}) begin
                stallCycles_d = stallCycles_q + CNT_W'(1);
            end
        end else begin
            dStage_d = '{instr: bus.instr_f, pc: bus.pc_f};
            eStage_d = '{instr: dStage_q.instr, pc: dStage_q.pc, a3: bus.a3_d};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dStage_q      <= EMPTY_D;
            eStage_q      <= EMPTY;
            mStage_q      <= EMPTY;
            wStage_q      <= EMPTY;
            bubbleE_q     <= 1'b0;
            stallCycles_q <= '0;
        end else begin
            dStage_q      <= dStage_d;
            eStage_q      <= eStage_d;
            mStage_q      <= mStage_d;
            wStage_q      <= wStage_d;
            bubbleE_q     <= bubbleE_d;
            stallCycles_q <= stallCycles_d;
        end
    end

    // pc_en is the only combinational output; everything else comes from registers
    assign bus.pc_en        = ~bus.stall | bus.flush;
    assign bus.instr_d      = dStage_q.instr;
    assign bus.pc_d         = dStage_q.pc;
    assign bus.instr_e      = eStage_q.instr;
    assign bus.pc_e         = eStage_q.pc;
    assign bus.a3_e         = eStage_q.a3;
    assign bus.instr_m      = mStage_q.instr;
    assign bus.pc_m         = mStage_q.pc;
    assign bus.a3_m         = mStage_q.a3;
    assign bus.instr_w      = wStage_q.instr;
    assign bus.pc_w         = wStage_q.pc;
    assign bus.a3_w         = wStage_q.a3;
    assign bus.bubble_e     = bubbleE_q;
    assign bus.stall_cycles = stallCycles_q;
endmodule
